// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU opcode and MIPS R-type funct constants, plus the control types
// used by the issue controller and its funct decoder.
package alu_issue_ctrl_pkg;

   // ALU operation codes understood by the ALU datapath
   localparam logic [3:0] ALU_SRL  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRA  = 4'b0010;
   localparam logic [3:0] ALU_ADDU = 4'b0100;
   localparam logic [3:0] ALU_SUBU = 4'b0101;
   localparam logic [3:0] ALU_AND  = 4'b0110;
   localparam logic [3:0] ALU_OR   = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_NOR  = 4'b1001;
   localparam logic [3:0] ALU_SLT  = 4'b1010;
   localparam logic [3:0] ALU_ADD  = 4'b1100;

   // MIPS R-type funct field values
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_SLLV = 6'b000100;
   localparam logic [5:0] FUNCT_SRLV = 6'b000110;
   localparam logic [5:0] FUNCT_SRAV = 6'b000111;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   // Source of an ALU operand
   typedef enum logic [1:0] {
      SEL_RS    = 2'd0,
      SEL_RT    = 2'd1,
      SEL_SHAMT = 2'd2
   } opnd_sel_e;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct decode: maps an R-type funct to an ALU opcode and the
// sources of operands A and B, flagging every unsupported funct as illegal.
module alu_funct_decode
   import alu_issue_ctrl_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [3:0] o_opcode,
   output opnd_sel_e  o_a_sel,
   output opnd_sel_e  o_b_sel,
   output logic       o_illegal
);

   // Decode table; SUBU and SLT swap operands because the ALU computes B-A and A>B
   always_comb begin
      o_opcode  = ALU_SRL;
      o_a_sel   = SEL_RS;
      o_b_sel   = SEL_RT;
      o_illegal = 1'b0;
      case (i_funct)
         FUNCT_SLL:  begin o_opcode = ALU_SLL;  o_a_sel = SEL_RT; o_b_sel = SEL_SHAMT; end
         FUNCT_SRL:  begin o_opcode = ALU_SRL;  o_a_sel = SEL_RT; o_b_sel = SEL_SHAMT; end
         FUNCT_SRA:  begin o_opcode = ALU_SRA;  o_a_sel = SEL_RT; o_b_sel = SEL_SHAMT; end
         FUNCT_SLLV: begin o_opcode = ALU_SLL;  o_a_sel = SEL_RT; o_b_sel = SEL_RS;    end
         FUNCT_SRLV: begin o_opcode = ALU_SRL;  o_a_sel = SEL_RT; o_b_sel = SEL_RS;    end
         FUNCT_SRAV: begin o_opcode = ALU_SRA;  o_a_sel = SEL_RT; o_b_sel = SEL_RS;    end
         FUNCT_ADD:  begin o_opcode = ALU_ADD;  end
         FUNCT_ADDU: begin o_opcode = ALU_ADDU; end
         FUNCT_SUBU: begin o_opcode = ALU_SUBU; o_a_sel = SEL_RT; o_b_sel = SEL_RS;    end
         FUNCT_AND:  begin o_opcode = ALU_AND;  end
         FUNCT_OR:   begin o_opcode = ALU_OR;   end
         FUNCT_XOR:  begin o_opcode = ALU_XOR;  end
         FUNCT_NOR:  begin o_opcode = ALU_NOR;  end
         FUNCT_SLT:  begin o_opcode = ALU_SLT;  o_a_sel = SEL_RT; o_b_sel = SEL_RS;    end
         default:    begin o_illegal = 1'b1;    end
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one R-type request at a time, drives the ALU from
// registered operands, captures the result and holds a response until consumed.
// Counts consumed signed-add overflow exceptions with saturation.
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
#(
   parameter int EXC_CNT_W = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic [5:0]           i_funct,
   input  logic [4:0]           i_shamt,
   input  logic [31:0]          i_rs_data,
   input  logic [31:0]          i_rt_data,
   output logic [3:0]           o_alu_opcode,
   output logic [31:0]          o_alu_op_A,
   output logic [31:0]          o_alu_op_B,
   input  logic [31:0]          i_alu_rslt,
   input  logic                 i_alu_zero,
   input  logic                 i_alu_carry,
   input  logic                 i_alu_ovfl,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [31:0]          o_rsp_data,
   output logic                 o_rsp_zero,
   output logic                 o_rsp_carry,
   output logic                 o_rsp_ovfl_exc,
   output logic                 o_rsp_illegal,
   output logic [EXC_CNT_W-1:0] o_exc_count
);

   state_e                state_q, state_d;
   logic [3:0]            opcode_q, opcode_d;
   logic [31:0]           op_a_q, op_a_d;
   logic [31:0]           op_b_q, op_b_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic                  rsp_zero_q, rsp_zero_d;
   logic                  rsp_carry_q, rsp_carry_d;
   logic                  rsp_exc_q, rsp_exc_d;
   logic                  rsp_illegal_q, rsp_illegal_d;
   logic [EXC_CNT_W-1:0]  exc_cnt_q, exc_cnt_d;

   logic [3:0]            dec_opcode;
   opnd_sel_e             dec_a_sel;
   opnd_sel_e             dec_b_sel;
   logic                  dec_illegal;

   alu_funct_decode u_decode (
      .i_funct   (i_funct),
      .o_opcode  (dec_opcode),
      .o_a_sel   (dec_a_sel),
      .o_b_sel   (dec_b_sel),
      .o_illegal (dec_illegal)
   );

   function automatic logic [31:0] pick_operand(input opnd_sel_e sel, input logic [31:0] rs,
                                                input logic [31:0] rt, input logic [4:0] shamt);
      case (sel)
         SEL_RT:    pick_operand = rt;
         SEL_SHAMT: pick_operand = {27'b0, shamt};
         default:   pick_operand = rs;
      endcase
   endfunction

   // State register; reset wins over any handshake in the same cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next state: illegal requests skip the ALU and answer directly
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (i_req_valid) state_d = dec_illegal ? ST_RESP : ST_ISSUE;
         ST_ISSUE: state_d = ST_RESP;
         ST_RESP:  if (i_rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs are pure functions of the state
   always_comb begin
      o_req_ready = (state_q == ST_IDLE);
      o_rsp_valid = (state_q == ST_RESP);
   end

   // Datapath next values: operands load on legal accept, response loads from the ALU in ISSUE
   always_comb begin
      opcode_d      = opcode_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      rsp_data_d    = rsp_data_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_carry_d   = rsp_carry_q;
      rsp_exc_d     = rsp_exc_q;
      rsp_illegal_d = rsp_illegal_q;
      exc_cnt_d     = exc_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               if (dec_illegal) begin
                  rsp_data_d    = '0;
                  rsp_zero_d    = 1'b0;
                  rsp_carry_d   = 1'b0;
                  rsp_exc_d     = 1'b0;
                  rsp_illegal_d = 1'b1;
               end else begin
                  opcode_d = dec_opcode;
                  op_a_d   = pick_operand(dec_a_sel, i_rs_data, i_rt_data, i_shamt);
                  op_b_d   = pick_operand(dec_b_sel, i_rs_data, i_rt_data, i_shamt);
               end
            end
         end
         ST_ISSUE: begin
            rsp_data_d    = i_alu_rslt;
            rsp_zero_d    = i_alu_zero;
            rsp_carry_d   = i_alu_carry;
            rsp_exc_d     = i_alu_ovfl && (opcode_q == ALU_ADD);
            rsp_illegal_d = 1'b0;
         end
         ST_RESP: begin
            if (i_rsp_ready && rsp_exc_q && (exc_cnt_q != '1)) exc_cnt_d = exc_cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath registers, all cleared by reset
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         opcode_q      <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         rsp_data_q    <= '0;
         rsp_zero_q    <= 1'b0;
         rsp_carry_q   <= 1'b0;
         rsp_exc_q     <= 1'b0;
         rsp_illegal_q <= 1'b0;
         exc_cnt_q     <= '0;
      end else begin
         opcode_q      <= opcode_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         rsp_data_q    <= rsp_data_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_carry_q   <= rsp_carry_d;
         rsp_exc_q     <= rsp_exc_d;
         rsp_illegal_q <= rsp_illegal_d;
         exc_cnt_q     <= exc_cnt_d;
      end
   end

   assign o_alu_opcode   = opcode_q;
   assign o_alu_op_A     = op_a_q;
   assign o_alu_op_B     = op_b_q;
   assign o_rsp_data     = rsp_data_q;
   assign o_rsp_zero     = rsp_zero_q;
   assign o_rsp_carry    = rsp_carry_q;
   assign o_rsp_ovfl_exc = rsp_exc_q;
   assign o_rsp_illegal  = rsp_illegal_q;
   assign o_exc_count    = exc_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by random
// requests, checked against a table-driven reference of the instruction set.
// The counter width is narrowed so that saturation is reachable quickly.
module tb_alu_issue_ctrl;

   localparam int CW = 3;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          i_req_valid;
   logic          o_req_ready;
   logic [5:0]    i_funct;
   logic [4:0]    i_shamt;
   logic [31:0]   i_rs_data;
   logic [31:0]   i_rt_data;
   logic [3:0]    o_alu_opcode;
   logic [31:0]   o_alu_op_A;
   logic [31:0]   o_alu_op_B;
   logic [31:0]   i_alu_rslt;
   logic          i_alu_zero;
   logic          i_alu_carry;
   logic          i_alu_ovfl;
   logic          o_rsp_valid;
   logic          i_rsp_ready;
   logic [31:0]   o_rsp_data;
   logic          o_rsp_zero;
   logic          o_rsp_carry;
   logic          o_rsp_ovfl_exc;
   logic          o_rsp_illegal;
   logic [CW-1:0] o_exc_count;

   int checks = 0;
   int errors = 0;

   // Reference state: last issued ALU command and the exception count
   logic [3:0]    mOpc;
   logic [31:0]   mA;
   logic [31:0]   mB;
   int            mCnt;

   logic [5:0]    legalF [14] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                                  6'b000111, 6'b100000, 6'b100001, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b101010};

   always #5 i_clk = ~i_clk;

   alu_issue_ctrl #(.EXC_CNT_W(CW)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_funct        (i_funct),
      .i_shamt        (i_shamt),
      .i_rs_data      (i_rs_data),
      .i_rt_data      (i_rt_data),
      .o_alu_opcode   (o_alu_opcode),
      .o_alu_op_A     (o_alu_op_A),
      .o_alu_op_B     (o_alu_op_B),
      .i_alu_rslt     (i_alu_rslt),
      .i_alu_zero     (i_alu_zero),
      .i_alu_carry    (i_alu_carry),
      .i_alu_ovfl     (i_alu_ovfl),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_data     (o_rsp_data),
      .o_rsp_zero     (o_rsp_zero),
      .o_rsp_carry    (o_rsp_carry),
      .o_rsp_ovfl_exc (o_rsp_ovfl_exc),
      .o_rsp_illegal  (o_rsp_illegal),
      .o_exc_count    (o_exc_count)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Instruction-set reference: what the ALU must be asked to do for a funct
   function automatic void refDecode(input logic [5:0] f, input logic [4:0] sh,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     output logic legal, output logic [3:0] opc,
                                     output logic [31:0] a, output logic [31:0] b);
      logic [31:0] shz;
      shz = {27'd0, sh};
      legal = 1'b1;
      opc = 4'd0; a = 32'd0; b = 32'd0;
      case (f)
         6'd0:  begin opc = 4'd1;  a = rt; b = shz; end
         6'd2:  begin opc = 4'd0;  a = rt; b = shz; end
         6'd3:  begin opc = 4'd2;  a = rt; b = shz; end
         6'd4:  begin opc = 4'd1;  a = rt; b = rs;  end
         6'd6:  begin opc = 4'd0;  a = rt; b = rs;  end
         6'd7:  begin opc = 4'd2;  a = rt; b = rs;  end
         6'd32: begin opc = 4'd12; a = rs; b = rt;  end
         6'd33: begin opc = 4'd4;  a = rs; b = rt;  end
         6'd35: begin opc = 4'd5;  a = rt; b = rs;  end
         6'd36: begin opc = 4'd6;  a = rs; b = rt;  end
         6'd37: begin opc = 4'd7;  a = rs; b = rt;  end
         6'd38: begin opc = 4'd8;  a = rs; b = rt;  end
         6'd39: begin opc = 4'd9;  a = rs; b = rt;  end
         6'd42: begin opc = 4'd10; a = rt; b = rs;  end
         default: legal = 1'b0;
      endcase
   endfunction

   // One full transaction; with consume=0 it returns while the response is still pending
   task automatic applyStimulus(input string nm, input logic [5:0] f, input logic [4:0] sh,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] rslt, input logic z, input logic c,
                                input logic ov, input int hold, input bit consume);
      logic        legal;
      logic [3:0]  opc;
      logic [31:0] a, b, eData;
      logic        eZ, eC, eExc, eIll;
      refDecode(f, sh, rs, rt, legal, opc, a, b);
      checkOutput({nm, "_req_ready_idle"}, {31'd0, o_req_ready}, 32'd1);
      i_req_valid = 1'b1; i_funct = f; i_shamt = sh; i_rs_data = rs; i_rt_data = rt;
      i_alu_rslt = rslt; i_alu_zero = z; i_alu_carry = c; i_alu_ovfl = ov;
      tick();
      i_req_valid = 1'b0;
      i_funct = 6'($urandom); i_rs_data = $urandom; i_rt_data = $urandom;
      if (legal) begin
         mOpc = opc; mA = a; mB = b;
         checkOutput({nm, "_issue_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
         checkOutput({nm, "_issue_req_ready"}, {31'd0, o_req_ready}, 32'd0);
         checkOutput({nm, "_issue_opcode"}, {28'd0, o_alu_opcode}, {28'd0, mOpc});
         checkOutput({nm, "_issue_A"}, o_alu_op_A, mA);
         checkOutput({nm, "_issue_B"}, o_alu_op_B, mB);
         tick();
         eData = rslt; eZ = z; eC = c; eExc = ov && (opc == 4'd12); eIll = 1'b0;
      end else begin
         eData = 32'd0; eZ = 1'b0; eC = 1'b0; eExc = 1'b0; eIll = 1'b1;
      end
      i_alu_rslt = $urandom; i_alu_zero = 1'($urandom); i_alu_carry = 1'($urandom);
      i_alu_ovfl = 1'($urandom);
      for (int k = 0; k <= hold; k++) begin
         checkOutput({nm, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd1);
         checkOutput({nm, "_rsp_req_ready"}, {31'd0, o_req_ready}, 32'd0);
         checkOutput({nm, "_rsp_data"}, o_rsp_data, eData);
         checkOutput({nm, "_rsp_flags"},
                     {28'd0, o_rsp_zero, o_rsp_carry, o_rsp_ovfl_exc, o_rsp_illegal},
                     {28'd0, eZ, eC, eExc, eIll});
         checkOutput({nm, "_rsp_alu_opcode"}, {28'd0, o_alu_opcode}, {28'd0, mOpc});
         checkOutput({nm, "_rsp_alu_A"}, o_alu_op_A, mA);
         checkOutput({nm, "_rsp_alu_B"}, o_alu_op_B, mB);
         if (k < hold) tick();
      end
      if (consume) begin
         i_rsp_ready = 1'b1;
         i_req_valid = 1'b1;
         tick();
         i_rsp_ready = 1'b0;
         i_req_valid = 1'b0;
         if (eExc && mCnt < (1 << CW) - 1) mCnt++;
         checkOutput({nm, "_done_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
         checkOutput({nm, "_done_req_ready"}, {31'd0, o_req_ready}, 32'd1);
         checkOutput({nm, "_exc_count"}, {{(32-CW){1'b0}}, o_exc_count}, 32'(mCnt));
         checkOutput({nm, "_done_alu_opcode"}, {28'd0, o_alu_opcode}, {28'd0, mOpc});
      end
   endtask

   // Everything the block must show right after a reset
   task automatic checkResetState(input string nm);
      mOpc = 4'd0; mA = 32'd0; mB = 32'd0; mCnt = 0;
      checkOutput({nm, "_req_ready"}, {31'd0, o_req_ready}, 32'd1);
      checkOutput({nm, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
      checkOutput({nm, "_alu"}, {28'd0, o_alu_opcode} | o_alu_op_A | o_alu_op_B, 32'd0);
      checkOutput({nm, "_rsp_data"}, o_rsp_data, 32'd0);
      checkOutput({nm, "_rsp_flags"},
                  {28'd0, o_rsp_zero, o_rsp_carry, o_rsp_ovfl_exc, o_rsp_illegal}, 32'd0);
      checkOutput({nm, "_exc_count"}, {{(32-CW){1'b0}}, o_exc_count}, 32'd0);
   endtask

   initial begin
      logic [5:0] f;
      i_reset = 1'b1; i_req_valid = 1'b0; i_rsp_ready = 1'b0;
      i_funct = 6'd0; i_shamt = 5'd0; i_rs_data = 32'd0; i_rt_data = 32'd0;
      i_alu_rslt = 32'd0; i_alu_zero = 1'b0; i_alu_carry = 1'b0; i_alu_ovfl = 1'b0;
      mOpc = 4'd0; mA = 32'd0; mB = 32'd0; mCnt = 0;
      tick(); tick();
      i_reset = 1'b0;
      checkResetState("reset");

      // SUBU swaps operands
      applyStimulus("subu", 6'b100011, 5'd0, 32'd5, 32'd12, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkOutput("subu_const_opcode", {28'd0, o_alu_opcode}, 32'h5);
      checkOutput("subu_const_A", o_alu_op_A, 32'd12);
      checkOutput("subu_const_B", o_alu_op_B, 32'd5);

      // Signed overflow counts only for ADD
      applyStimulus("add_ovfl", 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      checkOutput("add_ovfl_count_const", {{(32-CW){1'b0}}, o_exc_count}, 32'd1);
      applyStimulus("addu_ovfl", 6'b100001, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      checkOutput("addu_ovfl_count_const", {{(32-CW){1'b0}}, o_exc_count}, 32'd1);

      // JR is illegal and leaves the ALU command untouched
      applyStimulus("jr", 6'b001000, 5'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 0, 1'b1);

      // Back-pressure: ready low for five cycles, consumed on the sixth
      applyStimulus("hold", 6'b100100, 5'd0, 32'hF0F0_0F0F, 32'hFF00_FF00, 32'hF000_0F00, 1'b0, 1'b1, 1'b0, 4, 1'b1);

      // SLL by the largest shift amount
      applyStimulus("sll31", 6'b000000, 5'd31, 32'hAAAA_5555, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      checkOutput("sll31_const_B", o_alu_op_B, 32'd31);

      // Counter saturates at all-ones
      for (int n = 0; n < 8; n++)
         applyStimulus("sat", 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      checkOutput("sat_count_const", {{(32-CW){1'b0}}, o_exc_count}, 32'd7);

      // Reset while in ISSUE aborts the operation
      applyStimulus("rst_issue_pre", 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      i_req_valid = 1'b1; i_funct = 6'b100000; i_alu_ovfl = 1'b1;
      tick();
      i_req_valid = 1'b0;
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      checkResetState("rst_issue");
      tick();
      checkOutput("rst_issue_no_rsp", {31'd0, o_rsp_valid}, 32'd0);

      // Reset in RESP beats a simultaneous consume
      applyStimulus("rst_resp_a", 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0, 1'b1);
      applyStimulus("rst_resp_b", 6'b100000, 5'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1, 1'b0);
      i_reset = 1'b1; i_rsp_ready = 1'b1;
      tick();
      i_reset = 1'b0; i_rsp_ready = 1'b0;
      checkResetState("rst_resp");

      // Reset beats a request in IDLE
      i_reset = 1'b1; i_req_valid = 1'b1; i_funct = 6'b100101; i_rs_data = 32'hFFFF_FFFF;
      tick();
      i_reset = 1'b0; i_req_valid = 1'b0;
      checkResetState("rst_idle");

      // Random traffic, mostly legal functs
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) f = 6'($urandom);
         else f = legalF[$urandom_range(0, 13)];
         if ($urandom_range(0, 3) == 0) f = 6'b100000;
         applyStimulus("rand", f, 5'($urandom), $urandom, $urandom, $urandom,
                       1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
